// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core constants for the register-file writeback arbiter.
// Requester indices double as the grant_last encoding.
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam int unsigned NUM_REQ = 2;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins; on contention
// the requester other than the most recent winner wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and LSU writebacks onto one registered register-file
// write port and exposes combinational bypass of the in-flight write.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int unsigned AW   = regfile_wb_arbiter_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            we2,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic            byp1_hit,
  output logic [XLEN-1:0] byp1_data,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp2_data,
  output logic            grant_last
);

  import regfile_wb_arbiter_pkg::*;

  logic [1:0]      req_c;
  logic [1:0]      gnt_c;
  logic            idle_c;
  logic            xfer_c;
  logic            sel_lsu_c;

  logic            we2_q, we2_d;
  logic [AW-1:0]   wa3_q, wa3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            grant_last_q, grant_last_d;

  assign req_c = {lsu_valid, alu_valid};

  rr_arb2 u_rr_arb2 (
    .req  (req_c),
    .last (grant_last_q),
    .gnt  (gnt_c)
  );

  // With nobody asking, both readies sit high; no transfer can result.
  assign idle_c    = ~|req_c;
  assign alu_ready = gnt_c[REQ_ALU] | idle_c;
  assign lsu_ready = gnt_c[REQ_LSU] | idle_c;
  assign xfer_c    = |gnt_c;
  assign sel_lsu_c = gnt_c[REQ_LSU];

  // Writes to x0 still occupy the port but never assert the enable.
  always_comb begin
    we2_d        = 1'b0;
    wa3_d        = wa3_q;
    wd3_d        = wd3_q;
    grant_last_d = grant_last_q;
    if (xfer_c) begin
      wa3_d        = sel_lsu_c ? lsu_addr : alu_addr;
      wd3_d        = sel_lsu_c ? lsu_data : alu_data;
      we2_d        = (wa3_d != '0);
      grant_last_d = sel_lsu_c ? REQ_LSU : REQ_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we2_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      grant_last_q <= REQ_LSU;
    end else begin
      we2_q        <= we2_d;
      wa3_q        <= wa3_d;
      wd3_q        <= wd3_d;
      grant_last_q <= grant_last_d;
    end
  end

  assign we2        = we2_q;
  assign wa3        = wa3_q;
  assign wd3        = wd3_q;
  assign grant_last = grant_last_q;

  assign byp1_hit  = we2_q && (ra1 == wa3_q) && (ra1 != '0);
  assign byp1_data = byp1_hit ? wd3_q : '0;
  assign byp2_hit  = we2_q && (ra2 == wa3_q) && (ra2 != '0);
  assign byp2_data = byp2_hit ? wd3_q : '0;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 The block SHALL have parameter AW, default 5, meaning register address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports alu_valid (in, 1), alu_addr (in, AW), alu_data (in, XLEN) and alu_ready (out, 1): requester 0, the ALU writeback.
REQ-006 The block SHALL have ports lsu_valid (in, 1), lsu_addr (in, AW), lsu_data (in, XLEN) and lsu_ready (out, 1): requester 1, the load writeback.
REQ-007 The block SHALL have ports we2 (out, 1), wa3 (out, AW) and wd3 (out, XLEN): the register-file write port, all registered.
REQ-008 The block SHALL have ports ra1 and ra2 (in, AW each): register-file read addresses, snooped for bypass.
REQ-009 The block SHALL have ports byp1_hit and byp2_hit (out, 1 each) and byp1_data and byp2_data (out, XLEN each): combinational bypass results.
REQ-010 The block SHALL have port grant_last (out, 1): the requester granted most recently (0 = ALU, 1 = LSU).

Function
REQ-011 A transfer SHALL occur on requester i in a cycle where i_valid and i_ready are both high at posedge clk.
REQ-012 At most one requester SHALL be granted per cycle; the other's ready SHALL be low that cycle.
REQ-013 With only one requester valid, that requester SHALL be granted (ready high) regardless of priority.
REQ-014 With both valid, the requester not equal to grant_last SHALL be granted (round-robin).
REQ-015 With neither valid, both readies SHALL be high, no transfer occurs, and grant_last SHALL hold.
REQ-016 grant_last SHALL update to the granted requester's index on every transfer.
REQ-017 Write latency SHALL be exactly one cycle: a transfer at edge N SHALL drive we2/wa3/wd3 from edge N until edge N+1.
REQ-018 A transfer with addr == 0 SHALL be accepted (ready high), SHALL update grant_last, and SHALL leave we2 low the following cycle; wa3/wd3 SHALL still load.
REQ-019 With no transfer at an edge, we2 SHALL be 0 the following cycle; wa3/wd3 SHALL hold their values.
REQ-020 A requester SHALL hold addr/data stable while valid and not ready; the block SHALL NOT check this.
REQ-021 byp1_hit SHALL be we2 && (ra1 == wa3) && (ra1 != 0); byp1_data SHALL equal wd3 when hit, else 0. The same rule SHALL apply to ra2, byp2_hit and byp2_data.
REQ-022 The readiness outputs SHALL depend combinationally only on the valid inputs and grant_last; they SHALL NOT depend on addr or data.

Reset
REQ-023 While rst_n is low: we2=0, wa3=0, wd3=0, grant_last=1 (so ALU wins the first contention).
REQ-024 Reset assertion mid-write SHALL drop we2 immediately (asynchronously); the in-flight write SHALL be lost.
REQ-025 On the first edge after deassertion, normal arbitration SHALL apply with no extra idle cycles.

Structure
REQ-026 XLEN, AW and the requester index constants (REQ_ALU=0, REQ_LSU=1) SHALL live in the shared core package.
REQ-027 The round-robin grant logic SHALL be the sub-module rr_arb2 (inputs: req[1:0], last; output: one-hot gnt[1:0]); the write register and bypass compares SHALL stay in the top level.

Verification
REQ-028 Reset, then ALU only, addr=5, data=0xDEADBEEF: alu_ready=1; next cycle we2=1, wa3=5, wd3=0xDEADBEEF; the cycle after, we2=0.
REQ-029 Both valid for 4 cycles after reset (ALU addr 1..4, LSU addr 9..12): grant order SHALL be ALU, LSU, ALU, LSU; each loser SHALL hold its request until granted.
REQ-030 LSU addr=0, data=0x1234: lsu_ready=1; next cycle we2=0; grant_last=1.
REQ-031 ALU writes addr=7, data=0xA5A5A5A5 with ra1=7 and ra2=0 during the write cycle: byp1_hit=1, byp1_data=0xA5A5A5A5; byp2_hit=0, byp2_data=0.
REQ-032 rst_n asserted low in the cycle where we2=1: we2, wa3, wd3 SHALL go to 0 without waiting for a clock edge, and grant_last SHALL be 1.
REQ-033 Idle for 3 cycles after a transfer: both readies SHALL be 1, we2 SHALL be 0, and wa3/wd3/grant_last SHALL stay unchanged.
